// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame-state encoding and word-size constants.
// Used by both the SPI master and slave blocks.
package spi_pkg;

  localparam int SPI_MAX_BITS = 32;
  localparam int SPI_LEN_W    = $clog2(SPI_MAX_BITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    END
  } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle between a master and a slave.
// miso_oe lets the slave release a shared miso line between frames.
interface spi_slave_if;

  logic sck;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, output cs, output mosi, input miso, input miso_oe);
  modport slave  (input sck, input cs, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_sync.sv
// Multi-bit flop synchronizer with a per-bit reset value.
// Each bit is synchronized independently; DEPTH must be at least 2.
module spi_sync #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= {DEPTH{rst_val}};
    end else begin
      stage <= {stage[DEPTH-2:0], d};
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave, CPHA=0 style with selectable CPOL: samples mosi on the leading
// sck edge, changes miso on the trailing edge; frame length 1..31 bits.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_slave_if.slave              spi,
  input  logic                    mode,
  input  logic [SPI_LEN_W-1:0]    len,
  input  logic [SPI_MAX_BITS-1:0] tx_data,
  output logic [SPI_MAX_BITS-1:0] rx_data,
  output logic                    valid,
  output logic                    busy,
  output logic                    frame_err
);

  logic [2:0] sync_q;
  logic       s_sck, s_cs, s_mosi;
  logic       sck_prev, cs_prev;
  logic [SYNC_STAGES:0] fill;
  logic       armed;
  logic       cs_fall, cs_rise, sck_lead, sck_trail;

  spi_state_t state_q, state_d;
  logic [SPI_LEN_W-1:0]    len_q;
  logic [SPI_LEN_W-1:0]    cnt_q;
  logic [SPI_MAX_BITS-1:0] rx_sh;
  logic [SPI_MAX_BITS-1:0] tx_sh;
  logic [SPI_LEN_W:0]      tx_shamt;

  spi_sync #(
    .WIDTH(3),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .rst_val({mode, 1'b1, 1'b0}),
    .d      ({spi.sck, spi.cs, spi.mosi}),
    .q      (sync_q)
  );

  assign {s_sck, s_cs, s_mosi} = sync_q;

  // fill marks when the synchronizer holds real pin samples rather than reset
  // values; armed then requires cs to be seen high before a frame may start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_prev <= mode;
      cs_prev  <= 1'b1;
      fill     <= '0;
      armed    <= 1'b0;
    end else begin
      sck_prev <= s_sck;
      cs_prev  <= s_cs;
      fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
      if (fill[SYNC_STAGES] && s_cs) armed <= 1'b1;
    end
  end

  assign cs_fall   = armed & cs_prev & ~s_cs;
  assign cs_rise   = ~cs_prev & s_cs;
  assign sck_lead  = mode ? (sck_prev & ~s_sck) : (~sck_prev & s_sck);
  assign sck_trail = mode ? (~sck_prev & s_sck) : (sck_prev & ~s_sck);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case leaves it unassigned.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (cs_rise)             state_d = END;
        else if (cnt_q == len_q) state_d = HOLD;
      end
      HOLD:    if (cs_rise) state_d = END;
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Left-justify the response so its MSB sits at bit 31; len 0 shifts it out entirely.
  assign tx_shamt = (SPI_LEN_W+1)'(SPI_MAX_BITS) - {1'b0, len};

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rx_data   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            len_q <= len;
            cnt_q <= '0;
            rx_sh <= '0;
            tx_sh <= tx_data << tx_shamt;
          end
        end
        SHIFT: begin
          // A cs rising edge takes priority over any sck edge in the same cycle.
          if (!cs_rise) begin
            if (sck_lead && (cnt_q != len_q)) begin
              rx_sh <= {rx_sh[SPI_MAX_BITS-2:0], s_mosi};
              cnt_q <= cnt_q + 1'b1;
            end else if (sck_trail) begin
              tx_sh <= tx_sh << 1;
            end
          end
        end
        END: begin
          if ((cnt_q == len_q) && (len_q != '0)) begin
            rx_data <= rx_sh;
            valid   <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q == SHIFT) || (state_q == HOLD);
    spi.miso_oe = busy;
    spi.miso    = (state_q == SHIFT) ? tx_sh[SPI_MAX_BITS-1] : 1'b0;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on sck, cs and mosi (minimum 2).
REQ-002 clk  input  1  system clock (100 MHz nominal); the block has one clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sck  input  1  SPI clock from the master (asynchronous to clk).
REQ-005 cs  input  1  chip select from the master, active-low (asynchronous).
REQ-006 mosi  input  1  serial data from the master (asynchronous).
REQ-007 mode  input  1  idle sck level (CPOL); 0 = idle low, 1 = idle high.
REQ-008 len  input  5  frame length in bits, 1..31; sampled at frame start.
REQ-009 tx_data  input  32  response word; sampled at frame start.
REQ-010 miso  output  1  serial data to the master, MSB-first.
REQ-011 miso_oe  output  1  tri-state enable for the miso pad; high while the frame is active.
REQ-012 rx_data  output  32  last complete received word, LSB-aligned, upper bits zero.
REQ-013 valid  output  1  one-cycle pulse: rx_data was updated.
REQ-014 busy  output  1  high from frame start until frame end.
REQ-015 frame_err  output  1  one-cycle pulse: the frame ended with the wrong bit count, or len was 0.

Function
REQ-016 sck, cs and mosi SHALL each pass through a SYNC_STAGES flop synchronizer.
REQ-017 Edge detection SHALL compare the last synchronizer stage with one further registered copy.
REQ-018 The block SHALL support sck up to clk/8.
REQ-019 The leading edge is the sck transition away from the mode level; the trailing edge is the transition back to it.
REQ-020 State machine states: IDLE, SHIFT, HOLD, END.
REQ-021 IDLE -> SHIFT on a synchronized cs falling edge.
  - Same cycle: latch len and tx_data, clear the bit counter and rx shift register, assert busy and miso_oe, drive miso with tx_data[len-1].
REQ-022 SHIFT, leading edge: shift the synchronized mosi into the rx shift register LSB and increment the bit counter.
  - When the counter reaches len, go to HOLD.
REQ-023 SHIFT, trailing edge: drive miso with the next lower bit of the latched tx word.
REQ-024 HOLD: ignore sck edges and drive miso 0.
REQ-025 SHIFT or HOLD -> END on a synchronized cs rising edge.
REQ-026 END lasts one cycle, then IDLE.
  - Deassert busy and miso_oe.
  - Counter == len and len != 0: load rx_data from the shift register and pulse valid.
  - Otherwise: pulse frame_err and leave rx_data unchanged.
REQ-027 An sck edge detected in the same cycle as the cs rising edge SHALL be ignored; the cs rising edge wins.
REQ-028 sck edges in IDLE SHALL be ignored.
REQ-029 len = 0 SHALL shift no bits, hold miso at 0, and end with frame_err.
REQ-030 valid and frame_err SHALL never assert in the same cycle.
REQ-031 Bit widths: rx_data[len-1:0] holds the received bits MSB-first; rx_data[31:len] is zero.
REQ-032 Latency: valid asserts at most SYNC_STAGES+2 clk cycles after cs rises at the pin.

Reset
REQ-033 On rst: state IDLE; rx_data, shift registers and bit counter 0; miso 0, miso_oe 0, busy 0, valid 0, frame_err 0; synchronizer stages set to idle levels (cs 1, sck mode, mosi 0).
REQ-034 rst during a frame SHALL abort the frame with no valid or frame_err pulse.
REQ-035 After rst, a new frame SHALL begin only after cs has been seen high and then a falling edge detected; a frame already in progress at the pin is ignored.

Structure
REQ-036 Package spi_pkg SHALL hold the state enum (IDLE, SHIFT, HOLD, END) and the constant SPI_MAX_BITS = 32; the master and slave share it.
REQ-037 Synchronizer sub-module spi_sync (parameter width and depth, synchronous reset value input) SHALL be instantiated once for all three inputs.

Verification
REQ-038 Bench pairs spi_slave with the team SPI master (div 100). mode 0, len 8, master tx 0xA5, slave tx 0x3C -> slave rx_data 0x000000A5 with valid, master rx_data 0x3C.
REQ-039 mode 1, len 16, master tx 0x1234, slave tx 0xBEEF -> slave rx_data 0x00001234; master receives 0xBEEF.
REQ-040 len 31, alternating 0x55555555 both directions -> each rx_data equals the peer tx masked to 31 bits.
REQ-041 Bit-banged frame, len 8, cs raised after 5 leading edges -> frame_err pulse, no valid, rx_data keeps its previous value.
REQ-042 rst asserted after 4 bits of a len-8 frame, cs stays low -> no pulse; miso_oe 0 until cs toggles; the next full frame with 0x81 -> rx_data 0x81.
REQ-043 len 0 frame with 4 sck pulses -> frame_err, miso held 0.
